// File: rtl/clk_div_pkg.sv
// Shared constants and divisor clamping for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DIV_MIN     = 2;
    localparam int DEFAULT_DIV = 10_000_000;

    // Divisors below DIV_MIN would never wrap cleanly, so they run as DIV_MIN.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, pending-divisor shadow and registered tick/sq.
module clk_div_channel #(
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             busy
);
    import clk_div_pkg::*;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] shadow_q;
    logic             busy_q;
    logic             tick_p1;
    logic             sq_p1;

    logic             wrap;
    logic             sq_next;
    logic [DIV_W-1:0] shadow_eff;

    assign wrap       = (cnt == div_q - DIV_W'(1));
    assign sq_next    = (cnt >= (div_q >> 1));
    assign shadow_eff = DIV_W'(clamp_div(32'(shadow_q)));

    // Shadow is pure data; busy_q decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (wr) begin
            shadow_q <= wr_div;
        end
    end

    // Counter/output stage: a pending divisor only lands at cnt==0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_q   <= DIV_RST;
            busy_q  <= 1'b0;
            tick_p1 <= 1'b0;
            sq_p1   <= 1'b0;
        end else begin
            if (sync || !en) begin
                cnt     <= '0;
                tick_p1 <= 1'b0;
                sq_p1   <= 1'b0;
                if (busy_q) begin
                    div_q  <= shadow_eff;
                    busy_q <= 1'b0;
                end
            end else begin
                tick_p1 <= wrap;
                sq_p1   <= sq_next;
                if (wrap) begin
                    cnt <= '0;
                    if (busy_q) begin
                        div_q  <= shadow_eff;
                        busy_q <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
            // A write accepted alongside sync/wrap waits for the following wrap.
            if (wr) begin
                busy_q <= 1'b1;
            end
        end
    end

    assign tick = tick_p1;
    assign sq   = sq_p1;
    assign busy = busy_q;

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH runtime-programmable clock dividers sharing clk, with a valid/ready divisor port.
module clk_divider_multi #(
    parameter int   NUM_CH      = 4,
    parameter int   DIV_W       = 27,
    parameter int   DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter logic EN_RST      = 1'b1,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);
    localparam int CH_SPAN = 1 << CH_W;

    logic                first_q;
    logic [NUM_CH-1:0]   en_eff;
    logic [CH_SPAN-1:0]  ready_vec;

    // The first cycle out of reset runs with the reset enable value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
        end
    end

    assign en_eff    = first_q ? {NUM_CH{EN_RST}} : ch_en;
    assign cfg_ready = ready_vec[cfg_ch];

    genvar i;
    generate
        // Unused channel codes stay ready so writes to them are silently dropped.
        for (i = 0; i < CH_SPAN; i++) begin : g_ready
            if (i < NUM_CH) begin : g_live
                assign ready_vec[i] = !busy[i];
            end else begin : g_void
                assign ready_vec[i] = 1'b1;
            end
        end

        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic wr;
            assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

            clk_div_channel #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (en_eff[i]),
                .sync   (sync),
                .wr     (wr),
                .wr_div (cfg_div),
                .tick   (tick[i]),
                .sq     (sq[i]),
                .busy   (busy[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with 4 channels, 8-bit divisors, reset divisor 10.
module tb_clk_divider_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ch_en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    clk_divider_multi #(
        .NUM_CH      (4),
        .DIV_W       (8),
        .DEFAULT_DIV (10),
        .EN_RST      (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .sq        (sq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        ch_en     = 4'hF;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] dv);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
    endtask

    // Square output of a divide-by-10 channel running since reset release.
    function automatic logic sq10(input int k);
        return (k >= 1) && (((k - 1) % 10) >= 5);
    endfunction

    function automatic logic [3:0] rep4(input logic b);
        return {4{b}};
    endfunction

    logic [3:0] et, es;

    initial begin
        // Reset state
        reset_dut();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_sq", 32'(sq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);

        // Default divide-by-10 on every channel
        for (int k = 1; k <= 30; k++) begin
            step();
            check("p1_tick", 32'(tick), 32'(rep4(cyc % 10 == 0)));
            check("p1_sq", 32'(sq), 32'(rep4(sq10(cyc))));
        end

        // ch1 -> div 3 written at cycle 4, lands at the cycle-10 wrap
        reset_dut();
        step(); step(); step();
        write_cfg(2'd1, 8'd3);
        #1;
        check("p2_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("p2_busy4", 32'(busy), 32'h2);
        for (int k = 5; k <= 22; k++) begin
            step();
            et = rep4(cyc % 10 == 0);
            es = rep4(sq10(cyc));
            if (cyc >= 10) begin
                et[1] = ((cyc - 10) % 3 == 0);
                es[1] = ((cyc - 10) % 3 != 1);
            end
            check("p2_busy", 32'(busy), (cyc < 10) ? 32'h2 : 32'h0);
            check("p2_tick", 32'(tick), 32'(et));
            check("p2_sq", 32'(sq), 32'(es));
        end

        // Write to a busy channel is refused; another channel still accepts
        reset_dut();
        step();
        write_cfg(2'd1, 8'd5);
        step();
        write_cfg(2'd1, 8'd9);
        #1;
        check("p3_ready_busy", 32'(cfg_ready), 32'h0);
        step();
        write_cfg(2'd2, 8'd7);
        #1;
        check("p3_ready_free", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("p3_busy4", 32'(busy), 32'h6);
        for (int k = 5; k <= 20; k++) begin
            step();
            et = rep4(cyc % 10 == 0);
            et[1] = (cyc == 10) || (cyc == 15) || (cyc == 20);
            et[2] = (cyc == 10) || (cyc == 17);
            check("p3_busy", 32'(busy), (cyc < 10) ? 32'h6 : 32'h0);
            check("p3_tick", 32'(tick), 32'(et));
        end

        // ch3 divisors 0 and 1 both run as 2
        reset_dut();
        write_cfg(2'd3, 8'd0);
        step();
        cfg_valid = 1'b0;
        check("p4_busy1", 32'(busy), 32'h8);
        for (int k = 2; k <= 10; k++) begin
            step();
            check("p4_tick_a", 32'(tick), 32'(rep4(cyc % 10 == 0)));
        end
        check("p4_busy10", 32'(busy), 32'h0);
        write_cfg(2'd3, 8'd1);
        #1;
        check("p4_ready", 32'(cfg_ready), 32'h1);
        for (int k = 11; k <= 22; k++) begin
            step();
            if (cyc == 11) cfg_valid = 1'b0;
            et = rep4(cyc % 10 == 0);
            es = rep4(sq10(cyc));
            et[3] = (cyc % 2 == 0);
            es[3] = (cyc % 2 == 0);
            check("p4_busy", 32'(busy), (cyc == 11) ? 32'h8 : 32'h0);
            check("p4_tick", 32'(tick), 32'(et));
            check("p4_sq", 32'(sq), 32'(es));
        end

        // ch2 at 7, pending ch0 divisor 4, then sync restarts everything
        reset_dut();
        write_cfg(2'd2, 8'd7);
        step();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 11; k++) step();
        write_cfg(2'd0, 8'd4);
        step();
        cfg_valid = 1'b0;
        check("p5_busy12", 32'(busy), 32'h1);
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("p5_sync_tick", 32'(tick), 32'h0);
        check("p5_sync_sq", 32'(sq), 32'h0);
        check("p5_sync_busy", 32'(busy), 32'h0);
        for (int k = 15; k <= 24; k++) begin
            step();
            et = rep4(cyc == 24);
            et[0] = ((cyc - 14) % 4 == 0);
            et[2] = (cyc == 21);
            es = rep4((cyc - 15) >= 5);
            es[0] = (((cyc - 15) % 4) >= 2);
            es[2] = (((cyc - 15) % 7) >= 3);
            check("p5_tick", 32'(tick), 32'(et));
            check("p5_sq", 32'(sq), 32'(es));
        end

        // Reset mid-period with a pending write, then disable/re-enable ch0
        reset_dut();
        step(); step();
        write_cfg(2'd0, 8'd3);
        step();
        cfg_valid = 1'b0;
        step(); step();
        check("p6_busy5", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step();
        check("p6_rst_tick", 32'(tick), 32'h0);
        check("p6_rst_sq", 32'(sq), 32'h0);
        check("p6_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("p6_tick_div10", 32'(tick), 32'(rep4(cyc % 10 == 0)));
        end
        ch_en = 4'b1110;
        for (int k = 13; k <= 22; k++) begin
            step();
            check("p6_off_tick", 32'(tick), (cyc == 20) ? 32'hE : 32'h0);
            check("p6_off_sq", 32'(sq), 32'(rep4(sq10(cyc)) & 4'b1110));
        end
        ch_en = 4'hF;
        for (int k = 23; k <= 32; k++) begin
            step();
            et = (cyc == 30) ? 4'b1110 : 4'b0000;
            et[0] = (cyc == 32);
            es = rep4(sq10(cyc));
            es[0] = (cyc >= 28);
            check("p6_on_tick", 32'(tick), 32'(et));
            check("p6_on_sq", 32'(sq), 32'(es));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
